// File: rtl/baud_tick_gen_pkg.sv
// Shared types and defaults for the baud tick generator: prescale select enum,
// default widths and the prescale-to-count lookup.
package baud_tick_pkg;

  localparam int DEF_DIV_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OVS    = 16;

  typedef enum logic [1:0] {
    PRESC_1  = 2'd0,
    PRESC_4  = 2'd1,
    PRESC_16 = 2'd2,
    PRESC_64 = 2'd3
  } presc_e;

  // Number of clk_i cycles between prescaler ticks.
  function automatic logic [6:0] prescCount(input presc_e p);
    case (p)
      PRESC_1:  return 7'd1;
      PRESC_4:  return 7'd4;
      PRESC_16: return 7'd16;
      default:  return 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle of the baud tick generator; master drives configuration,
// slave (the generator) returns the tick pulses and the config error flag.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  // No valid/ready pair here: param_en_i is a one-cycle load strobe that is always
  // accepted at the edge it is sampled, and the ticks are one-cycle pulses with no
  // back-pressure. div_i/frac_i/presc_i only matter in the cycle param_en_i is high.
  logic              en_i;
  logic              param_en_i;
  logic [DIV_W-1:0]  div_i;
  logic [FRAC_W-1:0] frac_i;
  logic [1:0]        presc_i;
  logic              ovs_tick_o;
  logic              baud_tick_o;
  logic              cfg_err_o;

  modport master (
    output en_i, param_en_i, div_i, frac_i, presc_i,
    input  ovs_tick_o, baud_tick_o, cfg_err_o
  );

  modport slave (
    input  en_i, param_en_i, div_i, frac_i, presc_i,
    output ovs_tick_o, baud_tick_o, cfg_err_o
  );
endinterface

// File: rtl/baud_tick_gen_prescaler.sv
// Clock prescaler: emits a one-cycle preTick every 1/4/16/64 enabled cycles.
module baud_prescaler
  import baud_tick_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clear,
  input  logic   enable,
  input  presc_e presc,
  output logic   preTick
);

  logic [5:0] cnt;
  logic [5:0] lastCnt;

  assign lastCnt = 6'(prescCount(presc) - 7'd1);
  assign preTick = enable && (cnt == lastCnt);

  // Counter only moves while enabled, so pausing never loses prescaler phase.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= preTick ? '0 : cnt + 6'd1;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator with oversample and bit ticks.
// Define BAUD_TICK_GEN_FRAC_EN to build the fractional divisor accumulator.
module baud_tick_gen
  import baud_tick_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OVS    = DEF_OVS
) (
  input logic           clk_i,
  input logic           rst_i,
  baud_tick_gen_if.slave bus
);

  localparam int PH_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

  logic [DIV_W-1:0] divReg;
  logic [DIV_W-1:0] divCnt;
  presc_e           prescReg;
  logic [PH_W-1:0]  phase;
  logic             ovsTick;
  logic             baudTick;
  logic             cfgErr;
  logic             running;
  logic             preTick;
  logic             periodDone;
  logic [DIV_W:0]   periodLen;

  // A zero divisor parks everything, including the prescaler.
  assign running = bus.en_i && !cfgErr;

  baud_prescaler uPresc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (bus.param_en_i),
    .enable  (running),
    .presc   (prescReg),
    .preTick (preTick)
  );

`ifdef BAUD_TICK_GEN_FRAC_EN
  logic [FRAC_W-1:0] fracReg;
  logic [FRAC_W-1:0] fracAcc;
  logic              carryPend;

  // Accumulator overflow stretches the following period by one pre_tick.
  assign periodLen = {1'b0, divReg} + (DIV_W+1)'(carryPend);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fracReg   <= '0;
      fracAcc   <= '0;
      carryPend <= 1'b0;
    end else if (bus.param_en_i) begin
      fracReg   <= bus.frac_i;
      fracAcc   <= '0;
      carryPend <= 1'b0;
    end else if (periodDone) begin
      {carryPend, fracAcc} <= {1'b0, fracAcc} + {1'b0, fracReg};
    end
  end
`else
  assign periodLen = {1'b0, divReg};
`endif

  assign periodDone = preTick && (({1'b0, divCnt} + (DIV_W+1)'(1)) == periodLen);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      divReg   <= '0;
      prescReg <= PRESC_1;
      cfgErr   <= 1'b1;
      divCnt   <= '0;
      phase    <= '0;
      ovsTick  <= 1'b0;
      baudTick <= 1'b0;
    end else if (bus.param_en_i) begin
      divReg   <= bus.div_i;
      prescReg <= presc_e'(bus.presc_i);
      cfgErr   <= (bus.div_i == '0);
      divCnt   <= '0;
      phase    <= '0;
      ovsTick  <= 1'b0;
      baudTick <= 1'b0;
    end else begin
      ovsTick  <= periodDone;
      baudTick <= periodDone && (phase == PH_LAST);
      if (preTick) begin
        divCnt <= periodDone ? '0 : divCnt + DIV_W'(1);
      end
      if (periodDone) begin
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
      end
    end
  end

  assign bus.ovs_tick_o  = ovsTick;
  assign bus.baud_tick_o = baudTick;
  assign bus.cfg_err_o   = cfgErr;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: vector table of divisor settings plus
// hand-written sequences for reset, pause, zero divisor and fractional periods.
module tb_baud_tick_gen;
  import baud_tick_pkg::*;

  localparam int DIV_W  = DEF_DIV_W;
  localparam int FRAC_W = DEF_FRAC_W;
  localparam int OVS    = DEF_OVS;

  typedef struct {
    int div;
    int frac;
    int presc;
    int first;
    int period;
    int nTicks;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nVec = 0;
  int   nFail = 0;

  baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

  baud_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail + 1);
    $fatal(1, "watchdog");
  end

  // Driver / checker tasks; all sampling happens on the falling edge.
  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic loadCfg(input int d, input int f, input int p);
    @(negedge clk);
    bus.param_en_i = 1'b1;
    bus.div_i      = DIV_W'(d);
    bus.frac_i     = FRAC_W'(f);
    bus.presc_i    = 2'(p);
    @(negedge clk);
    bus.param_en_i = 1'b0;
  endtask

  // Cycles from the current falling edge to the next ovs tick; -1 if none within limit.
  task automatic waitTick(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit && lat < 0; k++) begin
      @(negedge clk);
      if (bus.ovs_tick_o) lat = k;
    end
  endtask

  task automatic countTicks(input int cycles, output int nOvs, output int nBaud);
    nOvs  = 0;
    nBaud = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.ovs_tick_o)  nOvs++;
      if (bus.baud_tick_o) nBaud++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat, nOvs, nBaud, acc, carry, tot, c, bLat;

    vecs.push_back('{div: 4, frac: 0, presc: 0, first: 4,   period: 4,   nTicks: 4});
    vecs.push_back('{div: 1, frac: 0, presc: 0, first: 1,   period: 1,   nTicks: 6});
    vecs.push_back('{div: 2, frac: 0, presc: 2, first: 32,  period: 32,  nTicks: 3});
    vecs.push_back('{div: 3, frac: 0, presc: 1, first: 12,  period: 12,  nTicks: 3});
    vecs.push_back('{div: 5, frac: 0, presc: 3, first: 320, period: 320, nTicks: 2});
`ifndef BAUD_TICK_GEN_FRAC_EN
    vecs.push_back('{div: 3, frac: 8, presc: 0, first: 3,   period: 3,   nTicks: 8});
`endif

    bus.en_i       = 1'b1;
    bus.param_en_i = 1'b0;
    bus.div_i      = '0;
    bus.frac_i     = '0;
    bus.presc_i    = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ovs", int'(bus.ovs_tick_o), 0);
    check("rst_baud", int'(bus.baud_tick_o), 0);
    check("rst_cfg_err", int'(bus.cfg_err_o), 1);

    // Reset wins over a simultaneous load of div=7
    bus.param_en_i = 1'b1;
    bus.div_i      = DIV_W'(7);
    @(negedge clk);
    rst            = 1'b0;
    bus.param_en_i = 1'b0;
    check("rst_vs_load_cfg_err", int'(bus.cfg_err_o), 1);
    countTicks(100, nOvs, nBaud);
    check("rst_vs_load_ovs", nOvs, 0);
    check("rst_vs_load_baud", nBaud, 0);

    // Vector table
    foreach (vecs[i]) begin
      loadCfg(vecs[i].div, vecs[i].frac, vecs[i].presc);
      check($sformatf("v%0d_load_ovs", i), int'(bus.ovs_tick_o), 0);
      check($sformatf("v%0d_cfg_err", i), int'(bus.cfg_err_o), 0);
      waitTick(vecs[i].first + 10, lat);
      check($sformatf("v%0d_first", i), lat, vecs[i].first);
      for (int j = 1; j < vecs[i].nTicks; j++) begin
        waitTick(vecs[i].period + 10, lat);
        check($sformatf("v%0d_period%0d", i, j), lat, vecs[i].period);
      end
    end

    // Baud tick every OVS ovs ticks, coincident with an ovs tick
    loadCfg(4, 0, 0);
    for (int b = 0; b < 2; b++) begin
      bLat  = -1;
      nOvs  = 0;
      for (int k = 1; k <= 200 && bLat < 0; k++) begin
        @(negedge clk);
        if (bus.ovs_tick_o) nOvs++;
        if (bus.baud_tick_o) begin
          bLat = k;
          check($sformatf("baud%0d_with_ovs", b), int'(bus.ovs_tick_o), 1);
        end
      end
      check($sformatf("baud%0d_lat", b), bLat, 64);
      check($sformatf("baud%0d_ovs_count", b), nOvs, OVS);
    end

    // Config inputs ignored without the load strobe
    loadCfg(4, 0, 0);
    bus.div_i   = DIV_W'(9);
    bus.presc_i = 2'd3;
    for (int j = 0; j < 3; j++) begin
      waitTick(20, lat);
      check($sformatf("ignore_cfg%0d", j), lat, 4);
    end

    // Enable low for 10 cycles mid-period delays the tick by exactly 10
    loadCfg(2, 0, 2);
    waitTick(50, lat);
    check("pause_first", lat, 32);
    c = 0;
    repeat (10) begin @(negedge clk); c++; end
    bus.en_i = 1'b0;
    countTicks(10, nOvs, nBaud);
    c += 10;
    check("pause_no_ovs", nOvs, 0);
    bus.en_i = 1'b1;
    waitTick(60, lat);
    check("pause_interval", (lat < 0) ? -1 : c + lat, 42);

    // Zero divisor parks the generator, then recovers on a good load
    loadCfg(0, 0, 0);
    check("div0_cfg_err", int'(bus.cfg_err_o), 1);
    countTicks(200, nOvs, nBaud);
    check("div0_ovs", nOvs, 0);
    check("div0_baud", nBaud, 0);
    check("div0_cfg_err_hold", int'(bus.cfg_err_o), 1);
    loadCfg(5, 0, 0);
    check("div5_cfg_err", int'(bus.cfg_err_o), 0);
    waitTick(20, lat);
    check("div5_first", lat, 5);

    // Reset mid-period aborts it and leaves no ticks
    loadCfg(4, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_cfg_err", int'(bus.cfg_err_o), 1);
    countTicks(100, nOvs, nBaud);
    check("midrst_ovs", nOvs, 0);

`ifdef BAUD_TICK_GEN_FRAC_EN
    // Fractional periods: 3 + carry of a 4-bit accumulator stepping by 8
    loadCfg(3, 8, 0);
    acc   = 0;
    carry = 0;
    tot   = 0;
    for (int j = 1; j <= 16; j++) begin
      waitTick(10, lat);
      check($sformatf("frac_period%0d", j), lat, 3 + carry);
      tot  += (lat < 0) ? 0 : lat;
      acc  += 8;
      carry = (acc >= 16) ? 1 : 0;
      acc   = acc % 16;
    end
    check("frac_16th_tick", tot, 55);
`else
    acc   = 0;
    carry = 0;
    tot   = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
